// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO
// Optional feature macro: UART_RX_PARITY_EN selects an 8E1 frame with a PARITY state.
// Ports: clk, resetn (sync active-low), rxd (async serial in, idles high),
//   i_pop (drop FIFO head), i_clr_err (clear sticky flags),
//   o_data (head byte, 0 when empty), o_valid (FIFO not empty),
//   o_overrun / o_frame_err / o_par_err (sticky error flags).
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE = 1_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  input  logic       i_pop,
  input  logic       i_clr_err,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_par_err
);
  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(CPB);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic s1_q, rx_s_q;
  logic [1:0] fill_q, fill_d;
  logic arm_q, arm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic pbad_q, pbad_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d;
  logic tick, push, fe_set, pe_set, empty, full, do_pop, do_push;
  always_comb begin
    tick = cnt_q == '0;
    state_d = state_q;
    cnt_d = tick ? cnt_q : cnt_q - CW'(1);
    idx_d = idx_q;
    sh_d = sh_q;
    pbad_d = pbad_q;
    push = 1'b0;
    fe_set = 1'b0;
    pe_set = 1'b0;
    fill_d = {fill_q[0], 1'b1};
    // After reset the receiver only rearms once the real line has been seen high,
    // so a frame cut by reset cannot be mistaken for a new start bit.
    arm_d = arm_q | (fill_q[1] & rx_s_q);
    case (state_q)
      IDLE: if (arm_q && !rx_s_q) begin
        state_d = START;
        cnt_d = HALF;
      end
      START: if (tick) begin
        state_d = rx_s_q ? IDLE : DATA;
        cnt_d = FULL;
        idx_d = '0;
        pbad_d = 1'b0;
      end
      DATA: if (tick) begin
        sh_d[idx_q] = rx_s_q;
        cnt_d = FULL;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        pbad_d = rx_s_q != ^sh_q;
        pe_set = rx_s_q != ^sh_q;
        cnt_d = FULL;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        push = rx_s_q & ~pbad_q;
        fe_set = ~rx_s_q;
        state_d = rx_s_q ? IDLE : BREAK;
      end
      BREAK: state_d = rx_s_q ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
    empty = wp_q == rp_q;
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    do_pop = i_pop & ~empty;
    // When full, a same-cycle pop frees the head slot that the write pointer aliases.
    do_push = push & (~full | do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wp_q[AW-1:0]] = sh_q;
    wp_d = wp_q + (AW+1)'(do_push);
    rp_d = rp_q + (AW+1)'(do_pop);
    ovr_d = (ovr_q & ~i_clr_err) | (push & full & ~do_pop);
    fe_d = (fe_q & ~i_clr_err) | fe_set;
    pe_d = (pe_q & ~i_clr_err) | pe_set;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      s1_q <= 1'b1;
      rx_s_q <= 1'b1;
      fill_q <= '0;
      arm_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      pbad_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      ovr_q <= 1'b0;
      fe_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q <= rxd;
      rx_s_q <= s1_q;
      fill_q <= fill_d;
      arm_q <= arm_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      pbad_q <= pbad_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      ovr_q <= ovr_d;
      fe_q <= fe_d;
      pe_q <= pe_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign o_valid = ~empty;
  assign o_data = empty ? 8'h00 : mem_q[rp_q[AW-1:0]];
  assign o_overrun = ovr_q;
  assign o_frame_err = fe_q;
  assign o_par_err = pe_q;
endmodule
